// File: rtl/fir_frame_ctrl.sv
// fir_frame_ctrl: frame sequencer around a streaming FIR. It feeds source samples, optionally
// flushes the delay line with zeros (build with FIR_FRAME_FLUSH_EN), and counts filtered results.
module fir_frame_ctrl #(
    parameter int DATA_WL       = 12,
    parameter int TAPS          = 15,
    parameter int LEN_WL        = 10,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_WL-1:0]  frame_len,
    input  logic               src_valid,
    output logic               src_ready,
    input  logic [DATA_WL-1:0] src_data,
    output logic [DATA_WL-1:0] fir_data_in,
    output logic               fir_in_valid,
    input  logic [DATA_WL-1:0] fir_data_out,
    input  logic               fir_out_valid,
    output logic [DATA_WL-1:0] dst_data,
    output logic               dst_valid,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int TMR_WL = $clog2(DRAIN_TIMEOUT + 1);
`ifdef FIR_FRAME_FLUSH_EN
    localparam bit FLUSH_ON = 1'b1;
    localparam int FLUSH_WL = $clog2(TAPS + 1);
`else
    localparam bit FLUSH_ON = 1'b0;
`endif
    // Extra results produced by the zero flush on top of one per input sample
    localparam logic [LEN_WL:0] EXP_ADD = FLUSH_ON ? (LEN_WL + 1)'(TAPS - 1) : '0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FEED  = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd3
`ifdef FIR_FRAME_FLUSH_EN
        ,
        FLUSH = 3'd4
`endif
    } state_t;

    state_t              state_r;
    logic [LEN_WL-1:0]   len_r;
    logic [LEN_WL-1:0]   in_cnt_r;
    logic [LEN_WL:0]     exp_r;
    logic [LEN_WL:0]     out_cnt_r;
    logic [TMR_WL-1:0]   timer_r;
`ifdef FIR_FRAME_FLUSH_EN
    logic [FLUSH_WL-1:0] flush_cnt_r;
`endif

    logic                accept_s;
    logic                out_ok_s;
    logic                out_drop_s;
    logic [LEN_WL:0]     out_cnt_nxt_s;

    // Classify each FIR result: counted while a frame is active and below E, otherwise dropped
    always_comb begin
        accept_s      = src_valid && src_ready;
        out_ok_s      = fir_out_valid && busy && (out_cnt_r < exp_r);
        out_drop_s    = fir_out_valid && !out_ok_s;
        out_cnt_nxt_s = out_ok_s ? (out_cnt_r + (LEN_WL + 1)'(1)) : out_cnt_r;
    end

    // Frame FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            len_r        <= '0;
            in_cnt_r     <= '0;
            exp_r        <= '0;
            out_cnt_r    <= '0;
            timer_r      <= '0;
`ifdef FIR_FRAME_FLUSH_EN
            flush_cnt_r  <= '0;
`endif
            src_ready    <= 1'b0;
            fir_in_valid <= 1'b0;
            fir_data_in  <= '0;
            dst_valid    <= 1'b0;
            dst_data     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            fir_in_valid <= 1'b0;
            fir_data_in  <= '0;
            dst_valid    <= out_ok_s;
            dst_data     <= out_ok_s ? fir_data_out : '0;
            done         <= 1'b0;
            out_cnt_r    <= out_cnt_nxt_s;
            if (out_drop_s) begin
                err <= 1'b1;
            end

            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (frame_len == '0) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                            err     <= 1'b1;
                        end else begin
                            state_r   <= FEED;
                            src_ready <= 1'b1;
                            busy      <= 1'b1;
                            len_r     <= frame_len;
                            in_cnt_r  <= '0;
                            out_cnt_r <= '0;
                            exp_r     <= {1'b0, frame_len} + EXP_ADD;
                            err       <= out_drop_s;
                        end
                    end
                end

                FEED: begin
                    if (accept_s) begin
                        fir_in_valid <= 1'b1;
                        fir_data_in  <= src_data;
                        in_cnt_r     <= in_cnt_r + LEN_WL'(1);
                        if (in_cnt_r == (len_r - LEN_WL'(1))) begin
                            src_ready <= 1'b0;
                            timer_r   <= '0;
`ifdef FIR_FRAME_FLUSH_EN
                            state_r     <= FLUSH;
                            flush_cnt_r <= '0;
`else
                            state_r     <= DRAIN;
`endif
                        end
                    end
                end

`ifdef FIR_FRAME_FLUSH_EN
                FLUSH: begin
                    // Zero samples push the last real inputs through the FIR delay line
                    fir_in_valid <= 1'b1;
                    fir_data_in  <= '0;
                    flush_cnt_r  <= flush_cnt_r + FLUSH_WL'(1);
                    if (flush_cnt_r == FLUSH_WL'(TAPS - 2)) begin
                        state_r <= DRAIN;
                        timer_r <= '0;
                    end
                end
`endif

                DRAIN: begin
                    if (out_cnt_nxt_s == exp_r) begin
                        state_r <= DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else if (fir_out_valid) begin
                        timer_r <= '0;
                    end else if (timer_r == TMR_WL'(DRAIN_TIMEOUT - 1)) begin
                        state_r <= DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        err     <= 1'b1;
                    end else begin
                        timer_r <= timer_r + TMR_WL'(1);
                    end
                end

                DONE: begin
                    state_r <= IDLE;
                end

                default: begin
                    state_r   <= IDLE;
                    src_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_frame_ctrl.sv
// Scoreboard bench for fir_frame_ctrl: an identity FIR model with 3-cycle latency feeds results
// back; expected fir_data_in and dst_data values are queued as stimulus is issued.
module tb_fir_frame_ctrl;

    localparam int DATA_WL       = 12;
    localparam int TAPS          = 15;
    localparam int LEN_WL        = 10;
    localparam int DRAIN_TIMEOUT = 64;
`ifdef FIR_FRAME_FLUSH_EN
    localparam int FLUSH_N = TAPS - 1;
`else
    localparam int FLUSH_N = 0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [LEN_WL-1:0]  frame_len = '0;
    logic               src_valid = 1'b0;
    logic [DATA_WL-1:0] src_data = '0;
    logic               fir_out_valid = 1'b0;
    logic [DATA_WL-1:0] fir_data_out = '0;
    logic               src_ready, fir_in_valid, dst_valid, busy, done, err;
    logic [DATA_WL-1:0] fir_data_in, dst_data;

    fir_frame_ctrl #(
        .DATA_WL(DATA_WL), .TAPS(TAPS), .LEN_WL(LEN_WL), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .fir_data_in(fir_data_in), .fir_in_valid(fir_in_valid),
        .fir_data_out(fir_data_out), .fir_out_valid(fir_out_valid),
        .dst_data(dst_data), .dst_valid(dst_valid),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic acc_q = 1'b0;

    logic [DATA_WL-1:0] fir_q[$];
    logic [DATA_WL-1:0] dst_q[$];
    int dst_seen, fin_seen, flush_seen, done_seen, dst_at_done;

    // hand-chosen Q4.8 samples: 1.0, -1.0, max, min, lsb, -lsb, 0.5, misc
    logic [DATA_WL-1:0] vec [8] = '{12'h100, 12'hF00, 12'h7FF, 12'h800,
                                    12'h001, 12'hFFF, 12'h080, 12'h3A5};

    // FIR model state
    logic               pv [3];
    logic [DATA_WL-1:0] pd [3];
    int emitted = 0;
    int limit = 1000;
    bit extra_req = 1'b0;
    int last_out = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) acc_q <= src_valid && src_ready;

    // Identity FIR with 3-cycle latency, optional output limit and injected stray pulse
    initial begin
        for (int k = 0; k < 3; k++) begin
            pv[k] = 1'b0;
            pd[k] = '0;
        end
        forever begin
            @(negedge clk);
            pv[2] = pv[1]; pd[2] = pd[1];
            pv[1] = pv[0]; pd[1] = pd[0];
            pv[0] = fir_in_valid; pd[0] = fir_data_in;
            if (extra_req) begin
                fir_out_valid = 1'b1;
                fir_data_out  = 12'h5A5;
                extra_req     = 1'b0;
                last_out      = cyc + 1;
            end else if (pv[2] && emitted < limit) begin
                fir_out_valid = 1'b1;
                fir_data_out  = pd[2];
                emitted++;
                last_out      = cyc + 1;
            end else begin
                fir_out_valid = 1'b0;
                fir_data_out  = '0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents data
    initial begin
        forever begin
            @(negedge clk);
            if (fir_in_valid === 1'b1) fin_seen++;
            if (acc_q) begin
                chk("fin_valid_after_accept", fir_in_valid, 1);
                if (fir_in_valid === 1'b1) begin
                    if (fir_q.size() > 0) chk("fir_data_in", fir_data_in, fir_q.pop_front());
                    else chk("fin_queue_empty", fir_q.size(), 1);
                end
            end else if (fir_in_valid === 1'b1) begin
                flush_seen++;
                chk("flush_data_zero", fir_data_in, 0);
            end
            if (dst_valid === 1'b1) begin
                dst_seen++;
                if (dst_q.size() > 0) chk("dst_data", dst_data, dst_q.pop_front());
                else chk("dst_extra", dst_valid, 0);
            end
            if (done === 1'b1) begin
                done_seen++;
                dst_at_done = dst_seen;
            end
        end
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic clear_counts();
        dst_seen = 0; fin_seen = 0; flush_seen = 0; done_seen = 0; dst_at_done = 0;
        emitted = 0;
    endtask

    task automatic start_frame(input int len);
        @(negedge clk);
        start = 1'b1;
        frame_len = LEN_WL'(len);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Feed n samples; toggle inserts a bubble every other cycle; poke pulses a stray start
    task automatic feed(input int n, input bit toggle, input int poke, input int stop_after);
        int i = 0;
        int g = 0;
        while (i < n && i < stop_after && g < 500) begin
            start = (g == poke);
            if (g == poke) frame_len = LEN_WL'(3);
            if (toggle && g[0]) begin
                src_valid = 1'b0;
            end else if (src_ready === 1'b1) begin
                src_valid = 1'b1;
                src_data  = vec[i % 8];
                fir_q.push_back(vec[i % 8]);
                dst_q.push_back(vec[i % 8]);
                i++;
            end else begin
                src_valid = 1'b0;
            end
            g++;
            @(negedge clk);
        end
        start = 1'b0;
        src_valid = 1'b0;
        if (i < stop_after) chk("feed_all_accepted", i, n);
        if (i == n) begin
            for (int k = 0; k < FLUSH_N; k++) dst_q.push_back('0);
        end
    endtask

    task automatic wait_done(input int bound, output int waited);
        waited = 0;
        while (done !== 1'b1 && waited < bound) begin
            @(negedge clk);
            waited++;
        end
    endtask

    initial begin
        int w;
        int dsr;

        // reset state
        idle(2);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_fir_in_valid", fir_in_valid, 0);
        chk("rst_dst_valid", dst_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        idle(2);

        // T1: 20 samples back to back, stray start mid-frame ignored
        clear_counts();
        start_frame(20);
        chk("t1_busy", busy, 1);
        feed(20, 1'b0, 5, 20);
        wait_done(300, w);
        chk("t1_done", done, 1);
        chk("t1_err", err, 0);
        idle(3);
        chk("t1_dst_at_done", dst_at_done, 20 + FLUSH_N);
        chk("t1_dst_count", dst_seen, 20 + FLUSH_N);
        chk("t1_flush_count", flush_seen, FLUSH_N);
        chk("t1_done_pulses", done_seen, 1);
        chk("t1_dst_q_left", dst_q.size(), 0);
        chk("t1_busy_after", busy, 0);

        // T2: 8 samples with src_valid toggling
        clear_counts();
        start_frame(8);
        feed(8, 1'b1, -1, 8);
        wait_done(300, w);
        chk("t2_done", done, 1);
        chk("t2_err", err, 0);
        idle(3);
        chk("t2_dst_count", dst_seen, 8 + FLUSH_N);
        chk("t2_fin_count", fin_seen, 8 + FLUSH_N);
        chk("t2_done_pulses", done_seen, 1);
        chk("t2_dst_q_left", dst_q.size(), 0);

        // T3: stray FIR output while IDLE
        clear_counts();
        extra_req = 1'b1;
        idle(4);
        chk("t3_idle_dst", dst_seen, 0);
        chk("t3_idle_err", err, 1);

        // T4: zero-length frame
        clear_counts();
        start_frame(0);
        wait_done(2, w);
        chk("t4_done", done, 1);
        chk("t4_err", err, 1);
        idle(3);
        chk("t4_fin_count", fin_seen, 0);
        chk("t4_done_pulses", done_seen, 1);

        // T5: FIR stops early, drain timeout
        clear_counts();
        limit = 8 + FLUSH_N - 3;
        start_frame(8);
        feed(8, 1'b0, -1, 8);
        wait_done(400, w);
        chk("t5_done", done, 1);
        chk("t5_timeout_cycles", cyc - last_out, DRAIN_TIMEOUT);
        chk("t5_err", err, 1);
        idle(3);
        chk("t5_dst_count", dst_seen, 8 + FLUSH_N - 3);
        chk("t5_dst_q_left", dst_q.size(), 3);
        dst_q.delete();
        fir_q.delete();
        limit = 1000;

        // T6: reset mid-FEED, then a normal frame
        clear_counts();
        start_frame(20);
        feed(20, 1'b0, -1, 10);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_src_ready", src_ready, 0);
        chk("t6_fir_in_valid", fir_in_valid, 0);
        chk("t6_fir_data_in", fir_data_in, 0);
        chk("t6_dst_valid", dst_valid, 0);
        chk("t6_dst_data", dst_data, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_err", err, 0);
        rst = 1'b0;
        fir_q.delete();
        dst_q.delete();
        dsr = dst_seen;
        idle(8);
        chk("t6_late_out_err", err, 1);
        chk("t6_late_out_dst", dst_seen, dsr);
        chk("t6_no_done", done_seen, 0);
        clear_counts();
        start_frame(8);
        chk("t6_restart_err_clear", err, 0);
        feed(8, 1'b0, -1, 8);
        wait_done(300, w);
        chk("t6_restart_done", done, 1);
        chk("t6_restart_err", err, 0);
        idle(3);
        chk("t6_restart_dst", dst_seen, 8 + FLUSH_N);
        chk("t6_restart_q_left", dst_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got time %0t, want completion", $time);
        $fatal(1);
    end

endmodule
